level_draw_arbiter: RTL and testbench

LEVEL_DRAW_ARBITER -- requirements
Module: level_draw_arbiter

---
 rtl/level_draw_arbiter_pkg.sv | 29 ++
 rtl/level_draw_arbiter_mux.sv | 31 +++
 rtl/level_draw_arbiter.sv | 96 +++++++++
 tb/tb_level_draw_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/level_draw_arbiter_pkg.sv
// Shared types and constants for the level draw arbiter: FSM states,
// transparent colour key and edge-code bit positions.
package level_draw_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } arb_state_t;

   localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

   localparam int EDGE_LEFT   = 3;
   localparam int EDGE_TOP    = 2;
   localparam int EDGE_RIGHT  = 1;
   localparam int EDGE_BOTTOM = 0;

   // Edge code contributed by one pixel: the level's code when it is a hit, else nothing.
   function automatic logic [3:0] hit_code(input logic hit, input logic [3:0] code);
      logic [3:0] masked;
      masked              = 4'h0;
      masked[EDGE_LEFT]   = hit & code[EDGE_LEFT];
      masked[EDGE_TOP]    = hit & code[EDGE_TOP];
      masked[EDGE_RIGHT]  = hit & code[EDGE_RIGHT];
      masked[EDGE_BOTTOM] = hit & code[EDGE_BOTTOM];
      return masked;
   endfunction

endpackage

// File: rtl/level_draw_arbiter_mux.sv
// Combinational priority compositor: lowest-index requesting, non-transparent
// layer wins; background colour otherwise.
module layer_priority_mux #(
   parameter int         NUM_LAYERS           = 4,
   parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
   parameter logic [7:0] BACKGROUND_RGB       = 8'h00
) (
   input  logic [NUM_LAYERS-1:0]   req,
   input  logic [NUM_LAYERS*8-1:0] rgb,
   output logic [7:0]              pixel
);

   logic [NUM_LAYERS-1:0] qualify;

   generate
      for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_qualify
         assign qualify[gi] = req[gi] && (rgb[8*gi +: 8] != TRANSPARENT_ENCODING);
      end
   endgenerate

   // Scan from the lowest priority upward so layer 0 overwrites last.
   always_comb begin
      pixel = BACKGROUND_RGB;
      for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
         if (qualify[k]) begin
            pixel = rgb[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/level_draw_arbiter.sv
// Layer compositor plus per-frame player/level collision detector with an
// edge-code report and a saturating collision-frame counter.
module level_draw_arbiter #(
   parameter int         NUM_LAYERS           = 4,
   parameter logic [7:0] TRANSPARENT_ENCODING = level_draw_arbiter_pkg::TRANSPARENT_ENCODING,
   parameter logic [7:0] BACKGROUND_RGB       = 8'h00
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic [NUM_LAYERS-1:0]   layerDrawingRequest,
   input  logic [NUM_LAYERS*8-1:0] layerRGB,
   input  logic [3:0]              levelHitEdgeCode,
   input  logic                    collisionEnable,
   input  logic                    clearCount,
   output logic [7:0]              RGBout,
   output logic                    collision,
   output logic [3:0]              collisionEdgeCode,
   output logic [7:0]              collisionCount
);

   import level_draw_arbiter_pkg::*;

   arb_state_t state;
   logic [3:0] accumulator;
   logic [3:0] snapshot;
   logic [7:0] composite;
   logic       pixel_hit;
   logic [3:0] pixel_code;
   logic       report_now;

   layer_priority_mux #(
      .NUM_LAYERS           (NUM_LAYERS),
      .TRANSPARENT_ENCODING (TRANSPARENT_ENCODING),
      .BACKGROUND_RGB       (BACKGROUND_RGB)
   ) u_mux (
      .req   (layerDrawingRequest),
      .rgb   (layerRGB),
      .pixel (composite)
   );

   assign pixel_hit  = layerDrawingRequest[0] & layerDrawingRequest[1] & collisionEnable;
   assign pixel_code = hit_code(pixel_hit, levelHitEdgeCode);

   // The frame summary is published on the edge entering REPORT so the pulse
   // lines up with the REPORT cycle; the snapshot gates that pulse.
   assign report_now = (state == ACCUM) && startOfFrame && (accumulator != 4'h0);
   assign collision  = (state == REPORT) && (snapshot != 4'h0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state             <= IDLE;
         RGBout            <= BACKGROUND_RGB;
         collisionEdgeCode <= 4'h0;
         collisionCount    <= 8'h00;
         accumulator       <= 4'h0;
         snapshot          <= 4'h0;
      end else begin
         RGBout <= composite;

         case (state)
            IDLE: begin
               if (startOfFrame) begin
                  accumulator <= pixel_code;
                  state       <= ACCUM;
               end
            end
            ACCUM: begin
               if (startOfFrame) begin
                  snapshot    <= accumulator;
                  accumulator <= pixel_code;
                  state       <= REPORT;
                  if (accumulator != 4'h0) begin
                     collisionEdgeCode <= accumulator;
                  end
               end else begin
                  accumulator <= accumulator | pixel_code;
               end
            end
            REPORT: begin
               // A startOfFrame here is illegal and treated as an ordinary pixel.
               accumulator <= accumulator | pixel_code;
               state       <= ACCUM;
            end
            default: state <= IDLE;
         endcase

         if (clearCount) begin
            collisionCount <= 8'h00;
         end else if (report_now && (collisionCount != 8'hFF)) begin
            collisionCount <= collisionCount + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_level_draw_arbiter.sv
// Directed bench for level_draw_arbiter: compositing, per-frame collision
// reporting, counter saturation/clear and mid-frame reset.
module tb_level_draw_arbiter;

   logic        clk;
   logic        resetN;
   logic        startOfFrame;
   logic [3:0]  layerDrawingRequest;
   logic [31:0] layerRGB;
   logic [3:0]  levelHitEdgeCode;
   logic        collisionEnable;
   logic        clearCount;
   logic [7:0]  RGBout;
   logic        collision;
   logic [3:0]  collisionEdgeCode;
   logic [7:0]  collisionCount;

   int compared;
   int mismatched;

   level_draw_arbiter dut (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (startOfFrame),
      .layerDrawingRequest (layerDrawingRequest),
      .layerRGB            (layerRGB),
      .levelHitEdgeCode    (levelHitEdgeCode),
      .collisionEnable     (collisionEnable),
      .clearCount          (clearCount),
      .RGBout              (RGBout),
      .collision           (collision),
      .collisionEdgeCode   (collisionEdgeCode),
      .collisionCount      (collisionCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one pixel, then let it be clocked and settle.
   task automatic step(input logic sof, input logic [3:0] req, input logic [31:0] rgb,
                       input logic [3:0] code, input logic cen, input logic clr);
      startOfFrame        = sof;
      layerDrawingRequest = req;
      layerRGB            = rgb;
      levelHitEdgeCode    = code;
      collisionEnable     = cen;
      clearCount          = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic chk_col(input string tag, input logic c, input logic [3:0] code, input logic [7:0] cnt);
      chk({tag, "_pulse"}, {31'b0, collision}, {31'b0, c});
      chk({tag, "_code"}, {28'b0, collisionEdgeCode}, {28'b0, code});
      chk({tag, "_count"}, {24'b0, collisionCount}, {24'b0, cnt});
   endtask

   initial begin
      compared            = 0;
      mismatched          = 0;
      resetN              = 1'b0;
      startOfFrame        = 1'b0;
      layerDrawingRequest = 4'b0000;
      layerRGB            = 32'h0;
      levelHitEdgeCode    = 4'h0;
      collisionEnable     = 1'b0;
      clearCount          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rgb", {24'b0, RGBout}, 32'h00);
      chk_col("reset", 1'b0, 4'h0, 8'h00);
      resetN = 1'b1;

      // Compositing
      step(1'b0, 4'b0110, 32'h00_92_65_00, 4'h0, 1'b0, 1'b0);
      chk("rgb_l1_over_l2", {24'b0, RGBout}, 32'h65);
      step(1'b0, 4'b0011, 32'h00_00_49_FF, 4'h0, 1'b0, 1'b0);
      chk("rgb_transparent_l0", {24'b0, RGBout}, 32'h49);
      step(1'b0, 4'b0000, 32'h11_22_33_44, 4'h0, 1'b0, 1'b0);
      chk("rgb_background", {24'b0, RGBout}, 32'h00);
      step(1'b0, 4'b1000, 32'hFF_00_00_00, 4'h0, 1'b0, 1'b0);
      chk("rgb_only_transparent", {24'b0, RGBout}, 32'h00);
      step(1'b0, 4'b1100, 32'h5A_C3_00_00, 4'h0, 1'b0, 1'b0);
      chk("rgb_l2_over_l3", {24'b0, RGBout}, 32'hC3);
      step(1'b0, 4'b1111, 32'h01_02_03_04, 4'h0, 1'b0, 1'b0);
      chk("rgb_all_l0", {24'b0, RGBout}, 32'h04);

      // First frame start: no report
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("first_sof", 1'b0, 4'h0, 8'h00);
      step(1'b0, 4'b0011, 32'h0, 4'h8, 1'b1, 1'b0);
      step(1'b0, 4'b0011, 32'h0, 4'h2, 1'b1, 1'b0);
      step(1'b0, 4'b0011, 32'h0, 4'h0, 1'b1, 1'b0);
      step(1'b0, 4'b0001, 32'h0, 4'h1, 1'b1, 1'b0);
      step(1'b0, 4'b0011, 32'h0, 4'h4, 1'b0, 1'b0);
      chk("no_pulse_mid_frame", {31'b0, collision}, 32'h0);
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("report_A", 1'b1, 4'hA, 8'h01);
      idle();
      chk_col("after_A", 1'b0, 4'hA, 8'h01);

      // Frame-start pixel hit belongs to the new frame
      step(1'b1, 4'b0011, 32'h0, 4'h4, 1'b1, 1'b0);
      chk_col("clean_frame", 1'b0, 4'hA, 8'h01);
      idle();
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("report_4", 1'b1, 4'h4, 8'h02);

      // startOfFrame during REPORT is ignored; its hit still accumulates
      step(1'b1, 4'b0011, 32'h0, 4'h1, 1'b1, 1'b0);
      chk_col("sof_in_report", 1'b0, 4'h4, 8'h02);
      idle();
      chk("still_quiet", {31'b0, collision}, 32'h0);
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("report_1", 1'b1, 4'h1, 8'h03);

      // Clear beats a simultaneous increment
      idle();
      step(1'b0, 4'b0011, 32'h0, 4'h2, 1'b1, 1'b0);
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk_col("clear_vs_inc", 1'b1, 4'h2, 8'h00);
      idle();

      // Saturation: iteration 0 reports a clean frame, later ones each count
      for (int i = 0; i <= 256; i++) begin
         step(1'b1, 4'b0011, 32'h0, 4'h8, 1'b1, 1'b0);
         if (i == 254) chk_col("sat_254", 1'b1, 4'h8, 8'd254);
         idle();
      end
      chk("sat_255", {24'b0, collisionCount}, 32'd255);
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("sat_hold", 1'b1, 4'h8, 8'd255);
      step(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk_col("clear_in_report", 1'b0, 4'h8, 8'h00);

      // Mid-frame reset discards the partial frame
      step(1'b0, 4'b0011, 32'h0, 4'h8, 1'b1, 1'b0);
      step(1'b0, 4'b0011, 32'hAB_CD_EF_12, 4'h2, 1'b1, 1'b0);
      chk("rgb_before_reset", {24'b0, RGBout}, 32'h12);
      #2 resetN = 1'b0;
      #1;
      chk("async_reset_rgb", {24'b0, RGBout}, 32'h00);
      chk_col("async_reset", 1'b0, 4'h0, 8'h00);
      idle();
      resetN = 1'b1;
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("post_reset_sof1", 1'b0, 4'h0, 8'h00);
      idle();
      step(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk_col("post_reset_sof2", 1'b0, 4'h0, 8'h00);
      chk("post_reset_rgb", {24'b0, RGBout}, 32'h00);
      idle();
      chk("post_reset_quiet", {31'b0, collision}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
